prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/cpux_pkg.sv | 18 +
 rtl/prog_loader_if.sv | 31 +++
 rtl/idle_timer.sv | 27 ++
 rtl/prog_loader.sv | 150 +++++++++++++++
 tb/tb_prog_loader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpux_pkg.sv
// Shared definitions for the program loader: state encoding, instruction
// memory geometry and the host idle timeout.
package cpux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    LOAD,
    DONE,
    ERR
  } state_t;

  localparam logic [15:0] IMEM_WORDS = 16'd1024;
  localparam int          IMEM_AW    = 10;
  localparam logic [15:0] TIMEOUT    = 16'hFFFF;

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream and instruction-memory write port of the program loader.
// The loader is the slave: it consumes bytes and produces memory writes.
interface prog_loader_if;
  import cpux_pkg::*;

  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               im_we;
  logic [IMEM_AW-1:0] im_addr;
  logic [31:0]        im_wdata;

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );

endinterface

// File: rtl/idle_timer.sv
// Counts consecutive enabled cycles without a host transfer. expired is
// raised during the cycle that would complete TIMEOUT idle cycles, so the
// owner leaves its waiting state exactly on that edge.
module idle_timer
  import cpux_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic kick,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt_q;

  // Idle-cycle counter: cleared by reset, by any transfer and while disabled; saturates.
  always_ff @(posedge clk) begin
    if (clr || kick || !en) begin
      cnt_q <= 16'd0;
    end else if (cnt_q != TIMEOUT) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign expired = en && !kick && (cnt_q == (TIMEOUT - 16'd1));

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a 2-byte word count followed by big-endian
// instruction bytes from a host, writes the assembled 32-bit words into
// instruction memory, and keeps the CPU in reset until the load completes.
module prog_loader
  import cpux_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  prog_loader_if.slave  bus,
  output logic          cpu_clr,
  output logic          done,
  output logic          err
);

  state_t             state_q;
  logic [15:0]        count_q;
  logic [23:0]        shift_q;
  logic [1:0]         byteCnt_q;
  logic [IMEM_AW:0]   wordIdx_q;
  logic               ready_q;
  logic               we_q;
  logic [IMEM_AW-1:0] addr_q;
  logic [31:0]        wdata_q;
  logic               done_q;
  logic               err_q;
  logic               cpuClr_q;

  logic               xfer;
  logic               timerEn;
  logic               expired;
  logic [15:0]        lenWord;

  assign xfer    = bus.byte_valid && ready_q;
  assign timerEn = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == LOAD);
  assign lenWord = {count_q[15:8], bus.byte_data};

  idle_timer u_idle_timer (
    .clk     (clk),
    .clr     (clr),
    .kick    (xfer),
    .en      (timerEn),
    .expired (expired)
  );

  // Loader FSM with registered outputs; ready_q drops during the final
  // write cycle so no stray byte is accepted before DONE is entered.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      count_q   <= 16'd0;
      shift_q   <= 24'd0;
      byteCnt_q <= 2'd0;
      wordIdx_q <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpuClr_q  <= 1'b1;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (load) begin
            state_q   <= LEN_HI;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpuClr_q  <= 1'b1;
            count_q   <= 16'd0;
            byteCnt_q <= 2'd0;
            wordIdx_q <= '0;
          end
        end
        LEN_HI: begin
          if (expired) begin
            state_q <= ERR;
            ready_q <= 1'b0;
            err_q   <= 1'b1;
          end else if (xfer) begin
            count_q[15:8] <= bus.byte_data;
            state_q       <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (expired) begin
            state_q <= ERR;
            ready_q <= 1'b0;
            err_q   <= 1'b1;
          end else if (xfer) begin
            count_q <= lenWord;
            if (lenWord == 16'd0) begin
              state_q  <= DONE;
              ready_q  <= 1'b0;
              done_q   <= 1'b1;
              cpuClr_q <= 1'b0;
            end else if (lenWord > IMEM_WORDS) begin
              state_q <= ERR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q   <= LOAD;
              wordIdx_q <= '0;
              byteCnt_q <= 2'd0;
            end
          end
        end
        LOAD: begin
          if (!ready_q) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            cpuClr_q <= 1'b0;
          end else if (expired) begin
            state_q <= ERR;
            ready_q <= 1'b0;
            err_q   <= 1'b1;
          end else if (xfer) begin
            shift_q   <= {shift_q[15:0], bus.byte_data};
            byteCnt_q <= byteCnt_q + 2'd1;
            if (byteCnt_q == 2'd3) begin
              we_q      <= 1'b1;
              wdata_q   <= {shift_q, bus.byte_data};
              addr_q    <= wordIdx_q[IMEM_AW-1:0];
              wordIdx_q <= wordIdx_q + 1'b1;
              if ((wordIdx_q + 1'b1) == count_q[IMEM_AW:0]) begin
                ready_q <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          ready_q  <= 1'b0;
          cpuClr_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.im_we      = we_q;
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = wdata_q;
  assign cpu_clr        = cpuClr_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a reference model derives the expected
// memory writes and final outcome from each byte stream; a monitor process
// checks every im_we against the queued expectations.
module tb_prog_loader;
  import cpux_pkg::*;

  typedef logic [7:0] byteQ_t[$];
  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic clr;
  logic load;
  logic cpu_clr;
  logic done;
  logic err;

  prog_loader_if bus ();

  prog_loader dut (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .bus     (bus),
    .cpu_clr (cpu_clr),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  lastWeCyc = -1;
  wr_t expQ[$];
  int  weCycQ[$];

  // Free-running cycle counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every write strobe is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_we", 1, 0);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("we_addr", 64'(bus.im_addr), 64'(e.addr));
        checkOutput("we_data", 64'(bus.im_wdata), 64'(e.data));
      end
      if (weCycQ.size() != 0) begin
        int c;
        c = weCycQ.pop_front();
        checkOutput("we_latency", 64'(cyc), 64'(c));
      end
      lastWeCyc = cyc;
    end
  end

  task automatic pulseLoad();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit mustBeReady, input bit withLoad);
    bit ok;
    ok = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    load = withLoad;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0 && mustBeReady) checkOutput("ready_no_stall", 64'(bus.byte_ready), 1);
      if (bus.byte_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("byte_ready_timeout", 0, 1);
      bus.byte_valid = 1'b0;
      load = 1'b0;
    end else begin
      @(posedge clk); #1;
      load = 1'b0;
    end
  endtask

  // Model the stream from the byte rules, queue expected writes, then drive it.
  // outcome: 0 = incomplete, 1 = done, 2 = err.
  task automatic applyStimulus(input byteQ_t bytes, input int gapMax, input bit doLoad,
                               input bit midLoad, output int outcome, output int nWords);
    int cnt;
    outcome = 0;
    nWords  = 0;
    cnt     = 0;
    if (bytes.size() >= 2) begin
      cnt = int'(bytes[0]) * 256 + int'(bytes[1]);
      if (cnt == 0) outcome = 1;
      else if (cnt > 1024) outcome = 2;
      else begin
        nWords = cnt;
        for (int w = 0; w < cnt; w++) begin
          if (2 + 4 * w + 3 < bytes.size()) begin
            wr_t e;
            e.addr = 10'(w);
            e.data = {bytes[2+4*w], bytes[3+4*w], bytes[4+4*w], bytes[5+4*w]};
            expQ.push_back(e);
          end
        end
        if (bytes.size() >= 2 + 4 * cnt) outcome = 1;
      end
    end
    if (doLoad) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom);
      @(posedge clk); #1;
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      bus.byte_valid = 1'b0;
    end
    for (int i = 0; i < bytes.size(); i++) begin
      int gap;
      gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
      if (gap > 0) begin
        bus.byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      sendByte(bytes[i], gapMax == 0, midLoad && i == 2);
      if (cnt >= 1 && cnt <= 1024 && i >= 2 && ((i - 2) % 4) == 3 && ((i - 2) / 4) < cnt)
        weCycQ.push_back(cyc);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic checkFinal(input string tag, input int outcome, input int nWords);
    bit seen;
    int endCyc;
    seen = 1'b0;
    endCyc = 0;
    if (outcome == 0) return;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin
        seen = 1'b1;
        endCyc = cyc;
        break;
      end
    end
    checkOutput({tag, "_finished"}, 64'(seen), 1);
    checkOutput({tag, "_done"}, 64'(done), (outcome == 1) ? 1 : 0);
    checkOutput({tag, "_err"}, 64'(err), (outcome == 2) ? 1 : 0);
    checkOutput({tag, "_cpu_clr"}, 64'(cpu_clr), (outcome == 1) ? 0 : 1);
    checkOutput({tag, "_ready"}, 64'(bus.byte_ready), 0);
    checkOutput({tag, "_pending"}, 64'(expQ.size()), 0);
    if (outcome == 1 && nWords > 0)
      checkOutput({tag, "_done_latency"}, 64'(endCyc), 64'(lastWeCyc + 1));
    expQ.delete();
    weCycQ.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, 64'(bus.byte_ready), 0);
    checkOutput({tag, "_we"}, 64'(bus.im_we), 0);
    checkOutput({tag, "_addr"}, 64'(bus.im_addr), 0);
    checkOutput({tag, "_wdata"}, 64'(bus.im_wdata), 0);
    checkOutput({tag, "_done"}, 64'(done), 0);
    checkOutput({tag, "_err"}, 64'(err), 0);
    checkOutput({tag, "_cpu_clr"}, 64'(cpu_clr), 1);
  endtask

  initial begin
    byteQ_t q;
    int outcome;
    int nWords;
    clr = 1'b1;
    load = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk); #1;
    clr = 1'b0;

    // Two-word program from the datasheet example.
    q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    applyStimulus(q, 0, 1'b1, 1'b0, outcome, nWords);
    checkFinal("two_words", outcome, nWords);

    // Zero-length program finishes with no writes.
    q = '{8'h00, 8'h00};
    applyStimulus(q, 1, 1'b1, 1'b0, outcome, nWords);
    checkFinal("zero_len", outcome, nWords);

    // Oversized length aborts; a later load restarts cleanly.
    q = '{8'h04, 8'h01};
    applyStimulus(q, 1, 1'b1, 1'b0, outcome, nWords);
    checkFinal("too_long", outcome, nWords);
    pulseLoad();
    @(negedge clk);
    checkOutput("reload_err", 64'(err), 0);
    checkOutput("reload_ready", 64'(bus.byte_ready), 1);
    checkOutput("reload_cpu_clr", 64'(cpu_clr), 1);
    @(posedge clk); #1;

    // Continue from LEN_HI with a load pulse mid-stream that must be ignored.
    q = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    applyStimulus(q, 0, 1'b0, 1'b1, outcome, nWords);
    checkFinal("after_err", outcome, nWords);

    // Three words back to back at one byte per cycle.
    q = '{8'h00, 8'h03};
    repeat (12) q.push_back(8'($urandom));
    applyStimulus(q, 0, 1'b1, 1'b0, outcome, nWords);
    checkFinal("b2b3", outcome, nWords);

    // Randomized programs with random host gaps.
    for (int t = 0; t < 6; t++) begin
      int n;
      n = int'($urandom_range(6, 1));
      q.delete();
      q.push_back(8'h00);
      q.push_back(8'(n));
      repeat (4 * n) q.push_back(8'($urandom));
      applyStimulus(q, (t % 3), 1'b1, 1'b0, outcome, nWords);
      checkFinal("random", outcome, nWords);
    end

    // Largest legal program: last write lands at address 1023.
    q.delete();
    q.push_back(8'h04);
    q.push_back(8'h00);
    repeat (4096) q.push_back(8'($urandom));
    applyStimulus(q, 0, 1'b1, 1'b0, outcome, nWords);
    checkFinal("full_mem", outcome, nWords);

    // Reset after three bytes of word 0, colliding with load and byte_valid.
    q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    applyStimulus(q, 0, 1'b1, 1'b0, outcome, nWords);
    clr = 1'b1;
    load = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hDD;
    @(posedge clk); #1;
    clr = 1'b0;
    load = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    checkResetState("mid_clr");
    repeat (5) @(posedge clk);
    checkOutput("mid_clr_pending", 64'(expQ.size()), 0);
    #1;

    // Host stalls after a partial word: no error one cycle short, error at the limit.
    q = '{8'h00, 8'h01, 8'h11, 8'h22};
    applyStimulus(q, 0, 1'b1, 1'b0, outcome, nWords);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    checkOutput("timeout_early_err", 64'(err), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("timeout_err", 64'(err), 1);
    checkOutput("timeout_cpu_clr", 64'(cpu_clr), 1);
    checkOutput("timeout_done", 64'(done), 0);
    checkOutput("timeout_pending", 64'(expQ.size()), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("timeout_err_hold", 64'(err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
